// File: rtl/slice_seq_pkg.sv
// Shared constants and FSM state type for the slice sequencer.
// The AC/DC timing defaults here are the values the top-level parameters start from.
package slice_seq_pkg;

  localparam int DCT_TIME_DEF       = 12;
  localparam int DC_VLC_TIME_DEF    = 44;
  localparam int AC_TAIL_DEF        = 6;
  localparam int AC_COEFS_PER_BLOCK = 63;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_window.sv
// Range window decoder: flags when counter lies inside [lo, hi]
// and reports how far counter has advanced past lo.
module seq_window #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] counter,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  output logic             active,
  output logic [CNT_W-1:0] offset
);

  assign active = (counter >= lo) && (counter <= hi);
  assign offset = counter - lo;

endmodule

// File: rtl/slice_sequencer.sv
// Slice sequencer: walks a per-slice cycle counter and opens the DC and AC
// VLC windows at the right offsets for the latched block count.
// Optional feature macro: SLICE_SEQ_QUEUE_EN (one-deep pending start slot).
module slice_sequencer
  import slice_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int BN_W        = 8,
  parameter int DCT_TIME    = DCT_TIME_DEF,
  parameter int DC_VLC_TIME = DC_VLC_TIME_DEF,
  parameter int AC_TAIL     = AC_TAIL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             slice_start,
  input  logic [BN_W-1:0]  block_num,
  output logic             busy,
  output logic [CNT_W-1:0] seq_counter,
  output logic             dc_vlc_active,
  output logic [CNT_W-1:0] dc_vlc_counter,
  output logic             ac_vlc_active,
  output logic [CNT_W-1:0] ac_vlc_counter,
  output logic             slice_done,
  output logic             start_error
);

  seq_state_t state;
  logic [BN_W-1:0]  bn;
  logic [CNT_W-1:0] bn_ext;
  logic [CNT_W-1:0] dc_lo;
  logic [CNT_W-1:0] dc_hi;
  logic [CNT_W-1:0] ac_lo;
  logic [CNT_W-1:0] end_cnt;
  logic             running;
  logic             at_end;
  logic             dc_win_active;
  logic             ac_win_active;
  logic [CNT_W-1:0] dc_off;
  logic [CNT_W-1:0] ac_off;

`ifdef SLICE_SEQ_QUEUE_EN
  logic             pending_valid;
  logic [BN_W-1:0]  pending_bn;
`endif

  // Window boundaries derived from the latched block count; all math wraps at CNT_W.
  assign bn_ext  = CNT_W'(bn);
  assign dc_lo   = CNT_W'(DCT_TIME) + bn_ext + CNT_W'(1);
  assign dc_hi   = CNT_W'(DCT_TIME) + bn_ext + CNT_W'(DC_VLC_TIME);
  assign ac_lo   = dc_hi + CNT_W'(1);
  assign end_cnt = dc_hi + (CNT_W'(AC_COEFS_PER_BLOCK) * bn_ext) + CNT_W'(AC_TAIL);

  assign running = (state == RUN);
  assign at_end  = running && (seq_counter == end_cnt);

  seq_window #(.CNT_W(CNT_W)) u_dc_window (
    .counter (seq_counter),
    .lo      (dc_lo),
    .hi      (dc_hi),
    .active  (dc_win_active),
    .offset  (dc_off)
  );

  seq_window #(.CNT_W(CNT_W)) u_ac_window (
    .counter (seq_counter),
    .lo      (ac_lo),
    .hi      (end_cnt),
    .active  (ac_win_active),
    .offset  (ac_off)
  );

  // Window outputs decode straight from the registered counter so they line up with it.
  assign dc_vlc_active  = running && dc_win_active;
  assign ac_vlc_active  = running && ac_win_active;
  assign dc_vlc_counter = dc_vlc_active ? dc_off : '0;
  assign ac_vlc_counter = ac_vlc_active ? ac_off : '0;
  assign slice_done     = at_end;

  // Sequencer FSM: launch, count, finish, and handle starts that arrive while busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      seq_counter   <= '0;
      bn            <= '0;
      busy          <= 1'b0;
      start_error   <= 1'b0;
`ifdef SLICE_SEQ_QUEUE_EN
      pending_valid <= 1'b0;
      pending_bn    <= '0;
`endif
    end else begin
      start_error <= 1'b0;
      case (state)
        IDLE: begin
          seq_counter <= '0;
          if (slice_start) begin
            bn    <= block_num;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (at_end) begin
            seq_counter <= '0;
`ifdef SLICE_SEQ_QUEUE_EN
            if (pending_valid) begin
              bn            <= pending_bn;
              pending_valid <= 1'b0;
              if (slice_start) begin
                start_error <= 1'b1;
              end
            end else if (slice_start) begin
              bn <= block_num;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
            if (slice_start) begin
              start_error <= 1'b1;
            end
`endif
          end else begin
            seq_counter <= seq_counter + CNT_W'(1);
`ifdef SLICE_SEQ_QUEUE_EN
            if (slice_start) begin
              if (pending_valid) begin
                start_error <= 1'b1;
              end else begin
                pending_valid <= 1'b1;
                pending_bn    <= block_num;
              end
            end
`else
            if (slice_start) begin
              start_error <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_sequencer.sv
// Scoreboard bench for slice_sequencer: stimulus pushes expected window/done/error
// events into a queue, a negedge monitor turns DUT activity into events and matches them.
// Build with SLICE_SEQ_QUEUE_EN defined to exercise the pending-start slot.
module tb_slice_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        slice_start = 1'b0;
  logic [7:0]  block_num = 8'd0;
  logic        busy;
  logic [15:0] seq_counter;
  logic        dc_vlc_active;
  logic [15:0] dc_vlc_counter;
  logic        ac_vlc_active;
  logic [15:0] ac_vlc_counter;
  logic        slice_done;
  logic        start_error;

  int total = 0;
  int bad   = 0;

  typedef enum int {
    EV_RST, EV_DC_FIRST, EV_DC_LAST, EV_AC_FIRST, EV_AC_LAST, EV_DONE, EV_POST, EV_ERR
  } evKind_t;

  typedef struct {
    evKind_t kind;
    int      seq;
    int      val;
  } expEv_t;

  expEv_t expQ[$];

  slice_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .slice_start    (slice_start),
    .block_num      (block_num),
    .busy           (busy),
    .seq_counter    (seq_counter),
    .dc_vlc_active  (dc_vlc_active),
    .dc_vlc_counter (dc_vlc_counter),
    .ac_vlc_active  (ac_vlc_active),
    .ac_vlc_counter (ac_vlc_counter),
    .slice_done     (slice_done),
    .start_error    (start_error)
  );

  always #5 clock = ~clock;

  // Plain value comparison used by the monitor's per-cycle invariants.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input evKind_t k, input int s, input int v);
    expEv_t e;
    e.kind = k;
    e.seq  = s;
    e.val  = v;
    expQ.push_back(e);
  endtask

  // A complete slice: DC window dcF..dcL, AC window acF..acL, done at acL,
  // then busy=postBusy with seq_counter=0 on the following cycle.
  task automatic pushSlice(input int dcF, input int dcL, input int acF, input int acL,
                           input int postBusy);
    pushExp(EV_DC_FIRST, dcF, 0);
    pushExp(EV_DC_LAST,  dcL, dcL - dcF);
    pushExp(EV_AC_FIRST, acF, 0);
    pushExp(EV_AC_LAST,  acL, acL - acF);
    pushExp(EV_DONE,     acL, 0);
    pushExp(EV_POST,     0,   postBusy);
  endtask

  // Match an observed event against the oldest expected event of the same kind.
  task automatic observe(input evKind_t k, input int s, input int v);
    int idx;
    idx = -1;
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].kind == k) begin
        idx = i;
        break;
      end
    end
    total++;
    if (idx < 0) begin
      bad++;
      $display("[TB] FAIL unexpected %s: got seq=%0d val=%0d (t=%0t)", k.name(), s, v, $time);
    end else begin
      if (expQ[idx].seq != s || expQ[idx].val != v) begin
        bad++;
        $display("[TB] FAIL %s: got seq=%0d val=%0d, want seq=%0d val=%0d (t=%0t)",
                 k.name(), s, v, expQ[idx].seq, expQ[idx].val, $time);
      end
      expQ.delete(idx);
    end
  endtask

  // One-cycle start request; called at posedge+1 so the next edge samples it.
  task automatic applyStimulus(input int bn);
    slice_start = 1'b1;
    block_num   = 8'(bn);
    @(posedge clock);
    #1;
    slice_start = 1'b0;
  endtask

  task automatic waitSeq(input int n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clock);
      #1;
      if (busy && int'(seq_counter) == n) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_seq_%0d: got timeout, want seq_counter reached", n);
    end
  endtask

  task automatic waitIdle();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clock);
      #1;
      if (!busy) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle: got timeout, want busy=0");
    end
  endtask

  logic rstAtEdge = 1'b0;
  logic monOn     = 1'b0;

  // Remember whether reset was applied at the edge just taken.
  always @(posedge clock) begin
    rstAtEdge <= reset;
    monOn     <= 1'b1;
  end

  int   prevSeq   = 0;
  int   prevDcCnt = 0;
  int   prevAcCnt = 0;
  logic prevDc    = 1'b0;
  logic prevAc    = 1'b0;
  logic prevBusy  = 1'b0;
  logic prevDone  = 1'b0;

  // Monitor: sample away from the active edge, check invariants, emit events.
  always @(negedge clock) begin
    if (monOn) begin
      checkOutput("dc_ac_overlap", int'(dc_vlc_active & ac_vlc_active), 0);
      if (!dc_vlc_active) checkOutput("dc_cnt_zero", int'(dc_vlc_counter), 0);
      if (!ac_vlc_active) checkOutput("ac_cnt_zero", int'(ac_vlc_counter), 0);
      if (dc_vlc_active && prevDc) checkOutput("dc_cnt_step", int'(dc_vlc_counter), prevDcCnt + 1);
      if (ac_vlc_active && prevAc) checkOutput("ac_cnt_step", int'(ac_vlc_counter), prevAcCnt + 1);
      if (!busy) checkOutput("idle_seq", int'(seq_counter), 0);
      if (busy && prevBusy && !prevDone && !rstAtEdge)
        checkOutput("seq_step", int'(seq_counter), prevSeq + 1);

      if (rstAtEdge)
        observe(EV_RST, int'(seq_counter),
                int'(busy | dc_vlc_active | ac_vlc_active | slice_done | start_error |
                     (|dc_vlc_counter) | (|ac_vlc_counter)));
      if (dc_vlc_active && !prevDc) observe(EV_DC_FIRST, int'(seq_counter), int'(dc_vlc_counter));
      if (!dc_vlc_active && prevDc) observe(EV_DC_LAST, prevSeq, prevDcCnt);
      if (ac_vlc_active && !prevAc) observe(EV_AC_FIRST, int'(seq_counter), int'(ac_vlc_counter));
      if (!ac_vlc_active && prevAc) observe(EV_AC_LAST, prevSeq, prevAcCnt);
      if (slice_done) observe(EV_DONE, int'(seq_counter), 0);
      if (prevDone) observe(EV_POST, int'(seq_counter), int'(busy));
      if (start_error) observe(EV_ERR, int'(seq_counter), 0);

      prevSeq   <= int'(seq_counter);
      prevDcCnt <= int'(dc_vlc_counter);
      prevAcCnt <= int'(ac_vlc_counter);
      prevDc    <= dc_vlc_active;
      prevAc    <= ac_vlc_active;
      prevBusy  <= busy;
      prevDone  <= slice_done;
    end
  end

  // Directed tests. With the default timing, END = 62 + 64*bn,
  // DC window = [13+bn, 56+bn], AC window = [57+bn, END].
  initial begin
    pushExp(EV_RST, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] bn=4 full slice");
    pushSlice(17, 60, 61, 318, 0);
    applyStimulus(4);
    waitIdle();

    $display("[TB] bn=0 slice");
    pushSlice(13, 56, 57, 62, 0);
    applyStimulus(0);
    waitIdle();

    $display("[TB] block_num changes mid-slice");
    pushSlice(17, 60, 61, 318, 0);
    applyStimulus(4);
    waitSeq(30);
    block_num = 8'd9;
    waitIdle();

    $display("[TB] reset mid-slice then restart");
    pushExp(EV_DC_FIRST, 17, 0);
    pushExp(EV_DC_LAST,  60, 43);
    pushExp(EV_AC_FIRST, 61, 0);
    pushExp(EV_AC_LAST,  100, 39);
    pushExp(EV_RST,      0, 0);
    applyStimulus(4);
    waitSeq(100);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    pushSlice(13, 56, 57, 62, 0);
    applyStimulus(0);
    waitIdle();

`ifdef SLICE_SEQ_QUEUE_EN
    $display("[TB] queued start plus overflow");
    pushSlice(17, 60, 61, 318, 1);
    pushExp(EV_ERR, 61, 0);
    pushSlice(15, 58, 59, 190, 0);
    applyStimulus(4);
    waitSeq(50);
    applyStimulus(2);
    waitSeq(60);
    applyStimulus(3);
    waitIdle();

    $display("[TB] start on slice_done cycle is queued");
    pushSlice(13, 56, 57, 62, 1);
    pushSlice(13, 56, 57, 62, 0);
    applyStimulus(0);
    waitSeq(62);
    applyStimulus(0);
    waitIdle();
`else
    $display("[TB] start during run is dropped");
    pushSlice(17, 60, 61, 318, 0);
    pushExp(EV_ERR, 51, 0);
    applyStimulus(4);
    waitSeq(50);
    applyStimulus(2);
    waitIdle();

    $display("[TB] start on slice_done cycle is dropped");
    pushSlice(13, 56, 57, 62, 0);
    pushExp(EV_ERR, 0, 0);
    applyStimulus(0);
    waitSeq(62);
    applyStimulus(0);
    waitIdle();
`endif

    repeat (10) @(posedge clock);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      foreach (expQ[i])
        $display("[TB] FAIL missing %s: got none, want seq=%0d val=%0d",
                 expQ[i].kind.name(), expQ[i].seq, expQ[i].val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
